// File: rtl/rx_fifo_pkg.sv
// Default geometry for the receive-side character buffer.
// The FIFO derives its pointer and count widths locally from Depth.
package rx_fifo_pkg;

  localparam int DEF_WDATA  = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_THRESH = 8;

endpackage

// File: rtl/fifo_mem.sv
// Depth x Wdata register array: one synchronous write port, one asynchronous read port.
// Shared by the RX and TX character buffers.
module fifo_mem #(
  parameter int Wdata = 8,
  parameter int Depth = 16,
  localparam int Aw   = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [Aw-1:0]    wr_addr,
  input  logic [Wdata-1:0] wr_data,
  input  logic [Aw-1:0]    rd_addr,
  output logic [Wdata-1:0] rd_data
);

  logic [Wdata-1:0] mem_reg [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // Show-ahead head entry must be visible without a read cycle.
  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/rx_fifo.sv
// Receive-side character FIFO: show-ahead valid/ready read port, fill level,
// threshold interrupt and sticky overrun flag.
module rx_fifo
  import rx_fifo_pkg::*;
#(
  parameter int Wdata  = DEF_WDATA,
  parameter int Depth  = DEF_DEPTH,
  parameter int Thresh = DEF_THRESH,
  localparam int Aw    = $clog2(Depth),
  localparam int Cw    = $clog2(Depth + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [Wdata-1:0] DIN,
  input  logic             WE,
  output logic [Wdata-1:0] DOUT,
  output logic             VALID,
  input  logic             READY,
  output logic [Cw-1:0]    LEVEL,
  output logic             IRQ,
  output logic             OVR,
  input  logic             CLRO
);

  logic [Aw-1:0] rd_ptr_reg, rd_ptr_next;
  logic [Aw-1:0] wr_ptr_reg, wr_ptr_next;
  logic [Cw-1:0] count_reg, count_next;
  logic          ovr_reg, ovr_next;

  logic full;
  logic pop;
  logic push;
  logic overrun;

  assign full    = (count_reg == Cw'(Depth));
  assign pop     = VALID && READY;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign push    = WE && (!full || pop);
  assign overrun = WE && full && !pop;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    ovr_next    = ovr_reg;

    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    if (push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end

    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push) begin
      count_next = count_reg - 1'b1;
    end

    // Setting wins over clearing so an overrun is never lost.
    if (overrun) begin
      ovr_next = 1'b1;
    end else if (CLRO) begin
      ovr_next = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      ovr_reg    <= 1'b0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      ovr_reg    <= ovr_next;
    end
  end

  fifo_mem #(
    .Wdata (Wdata),
    .Depth (Depth)
  ) u_mem (
    .clk     (CLK),
    .wr_en   (push),
    .wr_addr (wr_ptr_reg),
    .wr_data (DIN),
    .rd_addr (rd_ptr_reg),
    .rd_data (DOUT)
  );

  assign VALID = (count_reg != '0);
  assign LEVEL = count_reg;
  assign IRQ   = (count_reg >= Cw'(Thresh));
  assign OVR   = ovr_reg;

endmodule

// File: tb/tb_rx_fifo.sv
// Bench for rx_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int THRESH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       we = 1'b0;
  logic [7:0] dout;
  logic       valid;
  logic       ready = 1'b0;
  logic [4:0] level;
  logic       irq;
  logic       ovr;
  logic       clro = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_q[$];
  bit         m_ovr = 1'b0;

  rx_fifo #(
    .Wdata (8),
    .Depth (DEPTH),
    .Thresh(THRESH)
  ) dut (
    .CLK  (clk),
    .RST  (rst),
    .DIN  (din),
    .WE   (we),
    .DOUT (dout),
    .VALID(valid),
    .READY(ready),
    .LEVEL(level),
    .IRQ  (irq),
    .OVR  (ovr),
    .CLRO (clro)
  );

  always #5 clk = ~clk;

  // Reference model: a byte queue plus a sticky flag, updated from the
  // inputs seen at each rising edge.
  always @(posedge clk) begin
    bit m_pop;
    bit m_full;
    if (rst) begin
      m_q.delete();
      m_ovr = 1'b0;
    end else begin
      m_pop  = (m_q.size() > 0) && ready;
      m_full = (m_q.size() == DEPTH);
      if (m_pop) void'(m_q.pop_front());
      if (we && (!m_full || m_pop)) m_q.push_back(din);
      if (we && m_full && !m_pop) m_ovr = 1'b1;
      else if (clro) m_ovr = 1'b0;
    end
  end

  // Compare process: outputs are checked against the model on every falling edge.
  always @(negedge clk) begin
    checks++;
    if (valid !== (m_q.size() > 0)) begin
      failures++;
      $display("FAIL model_valid t=%0t got=%b exp=%b", $time, valid, m_q.size() > 0);
    end
    checks++;
    if (int'(level) != m_q.size() || $isunknown(level)) begin
      failures++;
      $display("FAIL model_level t=%0t got=%0d exp=%0d", $time, level, m_q.size());
    end
    checks++;
    if (irq !== (m_q.size() >= THRESH)) begin
      failures++;
      $display("FAIL model_irq t=%0t got=%b exp=%b", $time, irq, m_q.size() >= THRESH);
    end
    checks++;
    if (ovr !== m_ovr) begin
      failures++;
      $display("FAIL model_ovr t=%0t got=%b exp=%b", $time, ovr, m_ovr);
    end
    if (m_q.size() > 0) begin
      checks++;
      if (dout !== m_q[0]) begin
        failures++;
        $display("FAIL model_dout t=%0t got=%02h exp=%02h", $time, dout, m_q[0]);
      end
    end
  end

  task automatic expect_lit(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end else begin
      $display("check %s = %0h", name, got);
    end
  endtask

  // Apply one cycle of inputs, then wait until just after the rising edge.
  task automatic cycle(input bit w, input logic [7:0] d, input bit r,
                       input bit c, input bit rs);
    we = w; din = d; ready = r; clro = c; rst = rs;
    @(posedge clk);
    #1;
    we = 1'b0; ready = 1'b0; clro = 1'b0; rst = 1'b0;
  endtask

  initial begin
    logic [7:0] got_seq[$];
    bit         seen_aa;
    int         max_lvl;
    logic [7:0] last;

    cycle(0, 8'h00, 0, 0, 1);
    expect_lit("reset_valid", int'(valid), 0);
    expect_lit("reset_level", int'(level), 0);
    expect_lit("reset_irq", int'(irq), 0);
    expect_lit("reset_ovr", int'(ovr), 0);

    // Three pushes then three pops.
    cycle(1, 8'h41, 0, 0, 0);
    expect_lit("first_push_valid", int'(valid), 1);
    expect_lit("first_push_dout", int'(dout), 'h41);
    cycle(1, 8'h42, 0, 0, 0);
    cycle(1, 8'h43, 0, 0, 0);
    expect_lit("three_level", int'(level), 3);
    expect_lit("three_head", int'(dout), 'h41);
    cycle(0, 8'h00, 1, 0, 0);
    expect_lit("pop1_dout", int'(dout), 'h42);
    cycle(0, 8'h00, 1, 0, 0);
    expect_lit("pop2_dout", int'(dout), 'h43);
    cycle(0, 8'h00, 1, 0, 0);
    expect_lit("drained_valid", int'(valid), 0);
    expect_lit("drained_level", int'(level), 0);

    // Threshold interrupt.
    for (int i = 0; i < 7; i++) cycle(1, 8'(8'h10 + i), 0, 0, 0);
    expect_lit("lvl7_irq", int'(irq), 0);
    cycle(1, 8'h17, 0, 0, 0);
    expect_lit("lvl8_irq", int'(irq), 1);
    cycle(0, 8'h00, 1, 0, 0);
    expect_lit("pop_to7_irq", int'(irq), 0);

    // Overrun: fill to 16, push 0xAA while full.
    for (int i = 0; i < 9; i++) cycle(1, 8'(8'h20 + i), 0, 0, 0);
    expect_lit("full_level", int'(level), 16);
    cycle(1, 8'hAA, 0, 0, 0);
    expect_lit("ovr_level", int'(level), 16);
    expect_lit("ovr_set", int'(ovr), 1);
    seen_aa = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (dout == 8'hAA) seen_aa = 1'b1;
      cycle(0, 8'h00, 1, 0, 0);
    end
    expect_lit("dropped_absent", int'(seen_aa), 0);
    expect_lit("ovr_sticky", int'(ovr), 1);
    cycle(0, 8'h00, 0, 1, 0);
    expect_lit("ovr_cleared", int'(ovr), 0);

    // Push and pop together while full.
    for (int i = 0; i < 16; i++) cycle(1, 8'(8'h60 + i), 0, 0, 0);
    cycle(1, 8'h55, 1, 0, 0);
    expect_lit("fullpp_level", int'(level), 16);
    expect_lit("fullpp_ovr", int'(ovr), 0);
    last = 8'h00;
    for (int i = 0; i < 16; i++) begin
      last = dout;
      cycle(0, 8'h00, 1, 0, 0);
    end
    expect_lit("fullpp_last", int'(last), 'h55);

    // Pointer wrap with interleaved push/pop.
    got_seq.delete();
    max_lvl = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid) got_seq.push_back(dout);
      cycle(1, 8'(i), 1, 0, 0);
      if (int'(level) > max_lvl) max_lvl = int'(level);
    end
    while (valid && got_seq.size() < 40) begin
      got_seq.push_back(dout);
      cycle(0, 8'h00, 1, 0, 0);
    end
    expect_lit("wrap_count", got_seq.size(), 40);
    for (int i = 0; i < got_seq.size(); i++) begin
      if (got_seq[i] != 8'(i)) expect_lit("wrap_byte", int'(got_seq[i]), i);
    end
    expect_lit("wrap_maxlvl_le2", int'(max_lvl <= 2), 1);

    // Reset beats WE and CLRO.
    for (int i = 0; i < 5; i++) cycle(1, 8'(8'h30 + i), 0, 0, 0);
    expect_lit("pre_rst_level", int'(level), 5);
    cycle(1, 8'h99, 0, 1, 1);
    expect_lit("rst_valid", int'(valid), 0);
    expect_lit("rst_level", int'(level), 0);
    expect_lit("rst_ovr", int'(ovr), 0);
    expect_lit("rst_irq", int'(irq), 0);
    cycle(1, 8'h7E, 0, 0, 0);
    expect_lit("post_rst_head", int'(dout), 'h7E);

    // Randomized traffic, checked by the model on every cycle.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 5, $urandom_range(0, 999) < 5);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_fifo.md
Name: rx_fifo

Overview:
- Receive-side byte buffer directly downstream of the UART receiver.
- Captures each completed character (receiver data bus plus its one-cycle done strobe) into a circular buffer.
- Presents the oldest entry to the CPU/bus side through a show-ahead valid/ready interface.
- Reports fill level, a threshold interrupt and a sticky overrun flag so software can tolerate bursty line traffic.

Parameters:
- Wdata, 8, character width; must match the receiver's data width.
- Depth, 16, number of entries; power of two, at least 2.
- Thresh, 8, fill level at or above which IRQ asserts; range 1..Depth.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- DIN  in  Wdata  character from receiver; sampled only when WE=1.
- WE  in  1  one-cycle push strobe, connected to the receiver's done pulse.
- DOUT  out  Wdata  oldest stored character; meaningful only while VALID=1.
- VALID  out  1  buffer non-empty.
- READY  in  1  consumer pops the head entry when VALID&&READY.
- LEVEL  out  $clog2(Depth+1)  current number of stored entries.
- IRQ  out  1  LEVEL>=Thresh (level-sensitive, combinational from registered count).
- OVR  out  1  sticky overrun: a push was dropped because the buffer was full.
- CLRO  in  1  clears OVR.

Behaviour:
- Reset (RST=1 at a clock edge):
  - Read pointer, write pointer and count go to 0; OVR goes to 0.
  - Resulting outputs: VALID=0, LEVEL=0, IRQ=0.
  - Storage contents are not reset. DOUT is don't-care while VALID=0.
  - RST has priority over WE, READY and CLRO in the same cycle.
- Storage: Depth x Wdata array. Pointers are $clog2(Depth) bits and wrap naturally from Depth-1 to 0. The count register is separate and $clog2(Depth+1) bits wide.
- Push: WE=1 and (count<Depth or pop this cycle) writes DIN at the write pointer, then increments the write pointer.
- Pop: VALID&&READY increments the read pointer. DOUT = mem[read pointer], read combinationally from the storage registers.
- Latency: a push at edge N gives VALID=1 and DOUT=DIN after edge N (visible in cycle N+1). No bypass: DIN never appears on DOUT in the same cycle it is written.
- Count update:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
  - LEVEL = count.
- Full (count=Depth), WE=1, no pop:
  - The push is dropped; contents and pointers are unchanged.
  - OVR is set at that edge.
- Full with simultaneous pop and push: both are accepted, count stays Depth, OVR is not set.
- Empty with WE=1 and READY=1: only the push takes effect, because VALID is 0 that cycle. Count goes to 1.
- Pop while empty (READY=1, VALID=0): no effect; pointers and count are unchanged.
- OVR priority: set has priority over CLRO. If an overrun and CLRO occur in the same cycle, OVR ends at 1. Otherwise CLRO=1 clears OVR at the next edge.
- IRQ:
  - Combinational compare of count against Thresh.
  - Rises in the cycle after the push that brings count to Thresh.
  - Falls in the cycle after the pop that brings count below Thresh.
- WE held high for several cycles pushes once per cycle. The receiver never does this, but the FIFO must handle it.

Decomposition:
- No shared package is needed; pointer and count widths are local parameters derived from Depth.
- One sub-module is natural: fifo_mem, a Depth x Wdata register array with one synchronous write port and one asynchronous read port. A later TX-side buffer will reuse it.
- Pointer, count and flag logic stays in rx_fifo.

Test Plan:
- Reset, then push 0x41, 0x42, 0x43 on consecutive cycles with READY=0 -> VALID=1 from the cycle after the first push; LEVEL=3; DOUT=0x41. Then READY=1 for 3 cycles -> DOUT reads 0x41, 0x42, 0x43 in order; VALID=0 and LEVEL=0 afterwards.
- Push 8 bytes (Thresh=8) -> IRQ=0 at LEVEL=7 and IRQ=1 once LEVEL=8. One pop -> IRQ=0 the cycle after.
- Fill to 16, then push 0xAA with READY=0 -> LEVEL stays 16 and OVR=1. Draining all 16 entries must not yield 0xAA. CLRO=1 -> OVR=0 next cycle.
- At LEVEL=16, push 0x55 with READY=1 in the same cycle -> LEVEL stays 16 and OVR stays 0. After draining, 0x55 is the last byte out.
- Pointer wrap: 40 interleaved push/pop of an incrementing byte pattern -> output sequence matches input exactly and LEVEL never exceeds 2.
- With LEVEL=5, assert RST together with WE=1 and CLRO=1 -> next cycle VALID=0, LEVEL=0, OVR=0, IRQ=0. The subsequent push of 0x7E is read back as the first byte.
